// File: rtl/xif_multi_outstanding_accel_pkg.sv
// Shared types and helpers for the multi-outstanding XIF accelerator:
// slot payload, op decode and the single-cycle ALU evaluated at issue time.
package xif_multi_outstanding_accel_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned CNT_W  = 8;

   localparam logic [2:0] FUNCT3_ADDI = 3'b000;
   localparam logic [2:0] FUNCT3_SLLI = 3'b001;
   localparam logic [2:0] FUNCT3_XORI = 3'b010;

   typedef enum logic [1:0] {
      OP_ADDI,
      OP_SLLI,
      OP_XORI,
      OP_NONE
   } op_e;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  countdown;
      logic              committed;
      logic              killed;
   } slot_t;

   function automatic op_e decode(input logic [31:0] instr, input logic [6:0] opcode);
      op_e op;
      op = OP_NONE;
      if (instr[6:0] == opcode) begin
         case (instr[14:12])
            FUNCT3_ADDI: op = OP_ADDI;
            FUNCT3_SLLI: op = OP_SLLI;
            FUNCT3_XORI: op = OP_XORI;
            default:     op = OP_NONE;
         endcase
      end
      return op;
   endfunction

   // imm_s is the sign-extended immediate, imm_z the zero-extended one
   function automatic logic [DATA_W-1:0] alu(input op_e op, input logic [DATA_W-1:0] rs1,
                                             input logic [DATA_W-1:0] imm_s,
                                             input logic [DATA_W-1:0] imm_z);
      logic [DATA_W-1:0] res;
      res = '0;
      case (op)
         OP_ADDI: res = rs1 + imm_s;
         OP_SLLI: res = rs1 << imm_s[4:0];
         OP_XORI: res = rs1 ^ imm_z;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/xif_mo_slot_buffer.sv
// Circular in-flight slot buffer: allocation at tail, in-order free at head,
// commit/kill matching by XIF id and per-slot latency countdown.
module xif_mo_slot_buffer
   import xif_multi_outstanding_accel_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   alloc_i,
   input  slot_t                  alloc_slot_i,
   input  logic                   commit_valid_i,
   input  logic [ID_W-1:0]        commit_id_i,
   input  logic                   commit_kill_i,
   input  logic                   pop_i,
   output slot_t                  head_slot_o,
   output logic                   head_occupied_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   slot_t             slots [DEPTH];
   logic [DEPTH-1:0]  occupied;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W:0]    count;

   // Later assignments win: pop clears the head, then a same-cycle alloc may reuse it
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slots[PTR_W'(i)] <= '0;
         end
         occupied <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied[PTR_W'(i)]) begin
               if (slots[PTR_W'(i)].countdown != '0) begin
                  slots[PTR_W'(i)].countdown <= slots[PTR_W'(i)].countdown - CNT_W'(1);
               end
               if (commit_valid_i && (slots[PTR_W'(i)].id == commit_id_i) &&
                   !slots[PTR_W'(i)].committed && !slots[PTR_W'(i)].killed) begin
                  if (commit_kill_i) begin
                     slots[PTR_W'(i)].killed <= 1'b1;
                  end else begin
                     slots[PTR_W'(i)].committed <= 1'b1;
                  end
               end
            end
         end
         if (pop_i) begin
            slots[head]    <= '0;
            occupied[head] <= 1'b0;
            head           <= head + PTR_W'(1);
         end
         if (alloc_i) begin
            slots[tail]    <= alloc_slot_i;
            occupied[tail] <= 1'b1;
            tail           <= tail + PTR_W'(1);
         end
         if (alloc_i && !pop_i) begin
            count <= count + (PTR_W+1)'(1);
         end else if (!alloc_i && pop_i) begin
            count <= count - (PTR_W+1)'(1);
         end
      end
   end

   assign head_slot_o     = slots[head];
   assign head_occupied_o = occupied[head];
   assign count_o         = count;

endmodule

// File: rtl/xif_multi_outstanding_accel.sv
// CORE-V-XIF coprocessor with several instructions in flight: decodes and
// computes at issue, waits for commit/kill, returns results in issue order.
module xif_multi_outstanding_accel
   import xif_multi_outstanding_accel_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned IMM_WIDTH = 12,
   parameter int unsigned ID_WIDTH  = 4,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned LATENCY   = 3,
   parameter logic [6:0]  OPCODE    = 7'b1110111
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [31:0]         issue_instr_i,
   input  logic [ID_WIDTH-1:0] issue_id_i,
   input  logic [WIDTH-1:0]    issue_rs1_i,
   input  logic                issue_rs1_valid_i,
   output logic                issue_accept_o,
   output logic                issue_writeback_o,
   input  logic                commit_valid_i,
   input  logic [ID_WIDTH-1:0] commit_id_i,
   input  logic                commit_kill_i,
   output logic                result_valid_o,
   input  logic                result_ready_i,
   output logic [ID_WIDTH-1:0] result_id_o,
   output logic [4:0]          result_rd_o,
   output logic                result_we_o,
   output logic [WIDTH-1:0]    result_data_o,
   output logic                busy_o
);

   localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

   op_e                 op;
   logic                match;
   logic [IMM_WIDTH-1:0] imm;
   logic [DATA_W-1:0]   imm_s;
   logic [DATA_W-1:0]   imm_z;
   slot_t               alloc_slot;
   slot_t               head_slot;
   logic                head_occupied;
   logic                alloc;
   logic                pop;
   logic [CNT_BITS-1:0] count;
   logic                unused_rs1_field;

   assign unused_rs1_field = ^issue_instr_i[19:15];

   // Decode and issue handshake; readiness deliberately ignores same-cycle retirement
   always_comb begin
      op    = decode(issue_instr_i, OPCODE);
      match = (op != OP_NONE);
      imm   = issue_instr_i[31:32-IMM_WIDTH];
      imm_s = DATA_W'($signed(imm));
      imm_z = DATA_W'(imm);
      issue_accept_o    = match;
      issue_writeback_o = match;
      issue_ready_o     = match ? ((count < CNT_BITS'(DEPTH)) && issue_rs1_valid_i)
                                : issue_valid_i;
      alloc = issue_valid_i && issue_ready_o && match;
   end

   always_comb begin
      alloc_slot           = '0;
      alloc_slot.id        = ID_W'(issue_id_i);
      alloc_slot.rd        = issue_instr_i[11:7];
      alloc_slot.data      = alu(op, DATA_W'(issue_rs1_i), imm_s, imm_z);
      alloc_slot.countdown = CNT_W'(LATENCY);
   end

   // Head presents its result only once done and committed; a killed head drains silently
   always_comb begin
      result_valid_o = head_occupied && (head_slot.countdown == '0) &&
                       head_slot.committed && !head_slot.killed;
      pop            = head_occupied &&
                       (head_slot.killed || (result_valid_o && result_ready_i));
      result_we_o    = result_valid_o;
      result_id_o    = result_valid_o ? ID_WIDTH'(head_slot.id) : '0;
      result_rd_o    = result_valid_o ? head_slot.rd : '0;
      result_data_o  = result_valid_o ? WIDTH'(head_slot.data) : '0;
      busy_o         = (count != '0);
   end

   xif_mo_slot_buffer #(
      .DEPTH (DEPTH)
   ) u_slot_buffer (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .alloc_i         (alloc),
      .alloc_slot_i    (alloc_slot),
      .commit_valid_i  (commit_valid_i),
      .commit_id_i     (ID_W'(commit_id_i)),
      .commit_kill_i   (commit_kill_i),
      .pop_i           (pop),
      .head_slot_o     (head_slot),
      .head_occupied_o (head_occupied),
      .count_o         (count)
   );

endmodule

// File: tb/tb_xif_multi_outstanding_accel.sv
// Randomized self-checking bench for xif_multi_outstanding_accel against a
// queue-based model of in-order issue, commit/kill and timed results.
module tb_xif_multi_outstanding_accel;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned LATENCY = 3;
   localparam logic [6:0]  OPC     = 7'b1110111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_ready, issue_rs1_valid, issue_accept, issue_writeback;
   logic [31:0] issue_instr, issue_rs1;
   logic [3:0]  issue_id, commit_id, result_id;
   logic        commit_valid, commit_kill;
   logic        result_valid, result_ready, result_we, busy;
   logic [4:0]  result_rd;
   logic [31:0] result_data;

   always #5 clk = ~clk;

   xif_multi_outstanding_accel dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .issue_valid_i     (issue_valid),
      .issue_ready_o     (issue_ready),
      .issue_instr_i     (issue_instr),
      .issue_id_i        (issue_id),
      .issue_rs1_i       (issue_rs1),
      .issue_rs1_valid_i (issue_rs1_valid),
      .issue_accept_o    (issue_accept),
      .issue_writeback_o (issue_writeback),
      .commit_valid_i    (commit_valid),
      .commit_id_i       (commit_id),
      .commit_kill_i     (commit_kill),
      .result_valid_o    (result_valid),
      .result_ready_i    (result_ready),
      .result_id_o       (result_id),
      .result_rd_o       (result_rd),
      .result_we_o       (result_we),
      .result_data_o     (result_data),
      .busy_o            (busy)
   );

   typedef struct {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
      int          t;
      bit          committed;
      bit          killed;
   } ent_t;

   ent_t        q[$];
   int          seen_ids[$];
   int          now;
   int          n_checks;
   int          n_errors;
   bit          hold_pending;
   logic [3:0]  hold_id;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_instr(input logic [11:0] imm, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
      return {imm, 5'd0, f3, rd, opc};
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] instr, input logic [31:0] rs1);
      logic [11:0] imm;
      imm = instr[31:20];
      case (instr[14:12])
         3'b000:  return rs1 + {{20{imm[11]}}, imm};
         3'b001:  return rs1 << imm[4:0];
         default: return rs1 ^ {20'd0, imm};
      endcase
   endfunction

   // One clock cycle: drive, check against the model mid-cycle, advance the model
   task automatic step(input bit rst, input bit v, input logic [31:0] instr,
                       input logic [3:0] id, input logic [31:0] rs1, input bit rs1v,
                       input bit cv, input logic [3:0] cid, input bit ck, input bit rr);
      bit match, exp_ready, exp_rv, do_pop, hs;
      @(posedge clk);
      #1;
      rst_n = rst; issue_valid = v; issue_instr = instr; issue_id = id;
      issue_rs1 = rs1; issue_rs1_valid = rs1v; commit_valid = cv; commit_id = cid;
      commit_kill = ck; result_ready = rr;
      @(negedge clk);
      match     = (instr[6:0] == OPC) && (instr[14:12] < 3'd3);
      exp_ready = match ? ((q.size() < int'(DEPTH)) && rs1v) : v;
      exp_rv    = 1'b0;
      if (q.size() > 0) begin
         exp_rv = q[0].committed && !q[0].killed && ((now - q[0].t) >= int'(LATENCY));
      end
      if (hold_pending) begin
         check("hold_valid", 64'(result_valid), 64'(1));
         check("hold_id",    64'(result_id),    64'(hold_id));
         check("hold_rd",    64'(result_rd),    64'(hold_rd));
         check("hold_data",  64'(result_data),  64'(hold_data));
      end
      check("issue_ready",  64'(issue_ready),     64'(exp_ready));
      check("issue_accept", 64'(issue_accept),    64'(match));
      check("issue_wb",     64'(issue_writeback), 64'(match));
      check("busy",         64'(busy),            64'(q.size() != 0));
      check("result_valid", 64'(result_valid),    64'(exp_rv));
      check("result_we",    64'(result_we),       64'(exp_rv));
      if (exp_rv) begin
         check("result_id",   64'(result_id),   64'(q[0].id));
         check("result_rd",   64'(result_rd),   64'(q[0].rd));
         check("result_data", 64'(result_data), 64'(q[0].data));
         hold_id = q[0].id; hold_rd = q[0].rd; hold_data = q[0].data;
      end
      if (result_valid && rr) seen_ids.push_back(int'(result_id));
      hold_pending = rst && exp_rv && !rr;
      if (!rst) begin
         q.delete();
      end else begin
         do_pop = (q.size() > 0) && (q[0].killed || (exp_rv && rr));
         hs     = v && exp_ready && match;
         if (cv) begin
            foreach (q[i]) begin
               if (q[i].id == cid && !q[i].committed && !q[i].killed) begin
                  if (ck) q[i].killed = 1'b1;
                  else    q[i].committed = 1'b1;
               end
            end
         end
         if (do_pop) void'(q.pop_front());
         if (hs) q.push_back('{id, instr[11:7], ref_result(instr, rs1), now + 1, 1'b0, 1'b0});
      end
      now++;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int k = 0; k < n; k++) step(1, 0, '0, '0, '0, 0, 0, '0, 0, rr);
   endtask

   task automatic issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] rs1,
                        input bit rr);
      step(1, 1, instr, id, rs1, 1, 0, '0, 0, rr);
   endtask

   task automatic commit(input logic [3:0] id, input bit kill, input bit rr);
      step(1, 0, '0, '0, '0, 0, 1, id, kill, rr);
   endtask

   initial begin
      n_checks = 0; n_errors = 0; now = 0; hold_pending = 0;
      rst_n = 0; issue_valid = 0; issue_instr = '0; issue_id = '0; issue_rs1 = '0;
      issue_rs1_valid = 0; commit_valid = 0; commit_id = '0; commit_kill = 0; result_ready = 0;

      step(0, 0, '0, '0, '0, 0, 0, '0, 0, 0);
      step(0, 0, '0, '0, '0, 0, 0, '0, 0, 0);
      idle(1, 0);
      check("reset_valid", 64'(result_valid), 64'(0));
      check("reset_busy",  64'(busy),         64'(0));
      check("reset_data",  64'(result_data),  64'(0));

      // Single addi with imm=-1, committed one cycle after issue
      issue(4'd2, mk_instr(12'hFFF, 3'b000, 5'd5, OPC), 32'h10, 1);
      check("single_accept", 64'(issue_accept), 64'(1));
      commit(4'd2, 0, 1);
      idle(2, 1);
      check("single_early", 64'(result_valid), 64'(0));
      idle(1, 1);
      check("single_valid", 64'(result_valid), 64'(1));
      check("single_data",  64'(result_data),  64'(32'h0F));
      check("single_rd",    64'(result_rd),    64'(5));
      check("single_id",    64'(result_id),    64'(2));
      check("single_we",    64'(result_we),    64'(1));
      idle(2, 1);

      // Fill all slots, then out-of-order commits must still retire in order
      for (int k = 0; k < 4; k++)
         issue(4'(k), mk_instr(12'(k * 3 + 1), 3'(k % 3), 5'(k + 1), OPC), 32'(100 * k + 7), 1);
      issue(4'd9, mk_instr(12'd1, 3'b000, 5'd1, OPC), 32'd1, 1);
      check("full_ready", 64'(issue_ready), 64'(0));
      issue(4'd9, mk_instr(12'd1, 3'b000, 5'd1, 7'b0110011), 32'd1, 1);
      check("nomatch_ready",  64'(issue_ready),  64'(1));
      check("nomatch_accept", 64'(issue_accept), 64'(0));
      seen_ids.delete();
      commit(4'd3, 0, 1); commit(4'd1, 0, 1); commit(4'd0, 0, 1); commit(4'd2, 0, 1);
      idle(8, 1);
      check("ooo_count", 64'(seen_ids.size()), 64'(4));
      for (int k = 0; k < 4 && k < seen_ids.size(); k++) check("ooo_order", 64'(seen_ids[k]), 64'(k));

      // Kill the middle of three
      seen_ids.delete();
      for (int k = 4; k < 7; k++) issue(4'(k), mk_instr(12'h800, 3'b010, 5'(k), OPC), 32'hA5A5_0000, 1);
      commit(4'd5, 1, 1); commit(4'd4, 0, 1); commit(4'd6, 0, 1);
      idle(8, 1);
      check("kill_count", 64'(seen_ids.size()), 64'(2));
      if (seen_ids.size() == 2) begin
         check("kill_first",  64'(seen_ids[0]), 64'(4));
         check("kill_second", 64'(seen_ids[1]), 64'(6));
      end
      check("kill_busy", 64'(busy), 64'(0));

      // Backpressure at full, then retire alongside new issues
      for (int k = 8; k < 12; k++) issue(4'(k), mk_instr(12'(k), 3'b001, 5'(k), OPC), 32'(k), 0);
      commit(4'd8, 0, 0); commit(4'd9, 0, 0);
      idle(5, 0);
      check("bp_valid", 64'(result_valid), 64'(1));
      issue(4'd12, mk_instr(12'd5, 3'b000, 5'd12, OPC), 32'd12, 1);
      check("bp_full_block", 64'(issue_ready), 64'(0));
      issue(4'd12, mk_instr(12'd5, 3'b000, 5'd12, OPC), 32'd12, 1);
      check("bp_retire_issue", 64'(issue_ready), 64'(1));
      issue(4'd13, mk_instr(12'd6, 3'b000, 5'd13, OPC), 32'd13, 1);
      check("bp_count_same", 64'(issue_ready), 64'(1));
      issue(4'd14, mk_instr(12'd7, 3'b000, 5'd14, OPC), 32'd14, 1);
      check("bp_refull", 64'(issue_ready), 64'(0));
      for (int k = 10; k < 14; k++) commit(4'(k), 1, 1);
      idle(3, 1);

      // Reset with three slots in flight discards them
      for (int k = 1; k < 4; k++) issue(4'(k), mk_instr(12'd1, 3'b000, 5'(k), OPC), 32'd0, 1);
      step(0, 0, '0, '0, '0, 0, 0, '0, 0, 1);
      idle(1, 1);
      check("midrst_busy",  64'(busy),         64'(0));
      check("midrst_valid", 64'(result_valid), 64'(0));
      check("midrst_id",    64'(result_id),    64'(0));
      check("midrst_rd",    64'(result_rd),    64'(0));
      seen_ids.delete();
      commit(4'd1, 0, 1); commit(4'd2, 0, 1);
      idle(6, 1);
      check("midrst_noresult", 64'(seen_ids.size()), 64'(0));

      // Randomized traffic with mostly-live commit ids and rare resets
      for (int c = 0; c < 3000; c++) begin
         logic [31:0] ins;
         logic [3:0]  cid;
         ins = $urandom;
         if ($urandom_range(0, 9) < 8) ins[6:0] = OPC;
         ins[14:12] = 3'($urandom_range(0, 3));
         cid = 4'($urandom);
         if (q.size() > 0 && $urandom_range(0, 3) != 0) cid = q[$urandom_range(0, q.size() - 1)].id;
         step($urandom_range(0, 499) != 0, $urandom_range(0, 2) != 0, ins, 4'($urandom),
              $urandom, $urandom_range(0, 6) != 0, $urandom_range(0, 9) < 4, cid,
              $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/xif_multi_outstanding_accel.md
Name: xif_multi_outstanding_accel

Overview:
- Next-generation CORE-V-XIF coprocessor: several instructions in flight instead of one.
- Up to DEPTH issued instructions are tracked in a circular slot buffer.
- Each instruction computes its result with a fixed, parametrised latency, waits for its commit or kill by XIF id, and returns results in issue order.
- Sits behind the XIF issue/commit/result channels of the CPU; ports are flattened XIF fields so the block is standalone-verifiable. An interface wrapper maps if_xif onto them.

Parameters:
- WIDTH, 32, operand/result width
- IMM_WIDTH, 12, immediate width, taken from instr[31:32-IMM_WIDTH]
- ID_WIDTH, 4, XIF instruction id width
- DEPTH, 4, in-flight slots; power of two, at least 2
- LATENCY, 3, compute cycles from issue handshake to result available; at least 1
- OPCODE, 7'b1110111, custom opcode decoded

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- issue_valid_i  in  1  XIF issue valid
- issue_ready_o  out  1  XIF issue ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_rs1_i  in  WIDTH  rs1 value
- issue_rs1_valid_i  in  1  rs1 operand valid
- issue_accept_o  out  1  instruction is ours
- issue_writeback_o  out  1  writes rd
- commit_valid_i  in  1  commit valid
- commit_id_i  in  ID_WIDTH  committed/killed id
- commit_kill_i  in  1  kill instead of commit
- result_valid_o  out  1  result valid
- result_ready_i  in  1  result ready
- result_id_o  out  ID_WIDTH  result id
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable
- result_data_o  out  WIDTH  result value
- busy_o  out  1  any slot occupied

Behaviour:
- Decode: match = (instr[6:0]==OPCODE) and funct3 in {000,001,010}.
  - issue_accept_o = match; issue_writeback_o = match (combinational).
- Ops (imm = instr[31:32-IMM_WIDTH]):
  - 000: rs1 + sign-extended imm, modulo 2^WIDTH
  - 001: rs1 << imm[4:0]
  - 010: rs1 ^ zero-extended imm
- issue_ready_o:
  - non-match: equals issue_valid_i (reject immediately).
  - match: (count < DEPTH) and issue_rs1_valid_i. Never depends on same-cycle retirement.
- Issue handshake (valid and ready and match) writes the slot at the tail: id, rd=instr[11:7], result computed at issue, countdown=LATENCY, committed=0, killed=0. Tail advances and wraps modulo DEPTH.
- Each cycle, every occupied slot with countdown>0 decrements. done = (countdown==0).
- Commit: when commit_valid_i is high, every occupied slot whose id equals commit_id_i gets committed=1 (kill=0) or killed=1 (kill=1).
  - Unknown id is ignored.
  - A slot allocated in the same cycle is not matched.
  - A second commit to an already committed/killed slot is ignored.
- Head retirement:
  - head killed: slot is freed that cycle (regardless of done), no result, head advances.
  - head done and committed and not killed: result_valid_o=1, outputs driven from head slot registers, result_we_o=1.
  - On result_ready_i, slot freed and head advances.
  - result_valid_o stays high and outputs stay stable until ready (no drop).
- count: +1 on issue, -1 on retire; both in the same cycle leaves it unchanged. busy_o = (count != 0).
- Full: count==DEPTH blocks matching issues only.
- Reset (rst_ni low at clk_i edge, also mid-operation): all slots cleared, head=tail=count=0.
  - result_valid_o=0, result_we_o=0, result_id_o/rd_o/data_o=0, busy_o=0.
  - issue_* outputs follow their combinational rules.
- Earliest result: handshake at edge N gives result_valid_o high in cycle N+LATENCY, if committed by then.

Decomposition:
- Package xif_multi_outstanding_accel_pkg:
  - FUNCT3_ADDI/SLLI/XORI constants
  - op_e enum
  - slot_t struct (id, rd, data, countdown, committed, killed)
  - decode function
  - alu function (combinational result)
- Sub-module xif_mo_slot_buffer: circular buffer, head/tail/count, id CAM match for commit, countdown update.
- Top level: decode, ALU, handshakes.

Test Plan:
- Single op, LATENCY=3: issue addi imm=-1 with rs1=0x10, id=2, rd=5; commit id 2 at N+1 -> result_valid at N+3, data 0x0F, rd 5, id 2, we 1.
- Fill: 4 matching issues ids 0..3, no commits -> issue_ready low on 5th; issue of a non-matching opcode still gets ready=1, accept=0.
- Out-of-order commits: commit ids 3,1,0,2 -> results returned strictly in order 0,1,2,3.
- Kill middle: issue ids 4,5,6; kill 5, commit 4 and 6 -> results for 4 then 6 only; count returns to 0 and busy_o drops.
- Backpressure: result_ready low 5 cycles with result pending -> outputs held stable; then retire plus a new issue in the same cycle at full leaves count unchanged.
- Reset mid-flight with 3 slots occupied -> next cycle busy_o=0, result_valid_o=0; a later commit of an old id produces no result.
